// File: rtl/vs_fp_pkg.sv
// Shared types and constants for the fixed-point dot-product datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package vs_fp_pkg;

    typedef logic signed [31:0] fp_32_t;
    typedef logic signed [63:0] fp_64_t;

    // Symmetric ranges: the most negative code is never produced, so negation is always safe.
    localparam fp_32_t FP32_MAX = 32'sh7FFF_FFFF;
    localparam fp_32_t FP32_MIN = 32'sh8000_0001;
    localparam fp_64_t FP64_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam fp_64_t FP64_MIN = 64'sh8000_0000_0000_0001;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/vs_fp_sadd64.sv
// 64-bit signed saturating adder, clamps to [FP64_MIN, FP64_MAX].
// Latency: combinational.
// Backpressure: n/a.
// Ports: a_i, b_i operands; sum_o clamped sum; sat_o high when clamping occurred.
`timescale 1ns/1ps
module vs_fp_sadd64
    import vs_fp_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] sum_o,
    output logic        sat_o
);

    localparam logic signed [64:0] MAX_W = {1'b0, FP64_MAX};
    localparam logic signed [64:0] MIN_W = {1'b1, FP64_MIN};

    logic signed [64:0] wide;

    // One guard bit is enough to hold any sum of two 64-bit values exactly.
    assign wide = {a_i[63], a_i} + {b_i[63], b_i};

    always_comb begin
        sum_o = wide[63:0];
        sat_o = 1'b0;
        if (wide > MAX_W) begin
            sum_o = FP64_MAX;
            sat_o = 1'b1;
        end else if (wide < MIN_W) begin
            sum_o = FP64_MIN;
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/vs_fp_dot_acc.sv
// Streaming Q-format dot-product accumulator: multiply pairs, saturating-accumulate, emit acc>>>Q clamped.
// Latency: last element accepted at edge t -> out_valid at edge t+2.
// Backpressure: in_ready drops after the last element until the result handshake completes.
// Ports: clock/reset_n; in_valid/in_ready/a_in/b_in/in_last input stream;
//        out_valid/out_ready/result/term_count/sat result stream.
`timescale 1ns/1ps
module vs_fp_dot_acc
    import vs_fp_pkg::*;
#(
    parameter int Q     = 15,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a_in,
    input  logic [31:0]      b_in,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [CNT_W-1:0] term_count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             p1_vld_q, p1_last_q, p2_last_q;
    fp_64_t           p1_prod_q, acc_q;
    logic             sat_acc_q;
    logic [CNT_W-1:0] cnt_q;
    fp_32_t           result_q;
    logic [CNT_W-1:0] term_count_q;
    logic             sat_q;

    logic             accept, flush_done;
    fp_32_t           a_s, b_s;
    fp_64_t           prod, acc_sum, acc_sh;
    logic             acc_sat;
    fp_32_t           fin_res;
    logic             fin_clamp;

    assign accept = in_valid && in_ready_q;
    assign a_s    = a_in;
    assign b_s    = b_in;
    assign prod   = fp_64_t'(a_s) * fp_64_t'(b_s);

    vs_fp_sadd64 u_sadd (
        .a_i   (acc_q),
        .b_i   (p1_prod_q),
        .sum_o (acc_sum),
        .sat_o (acc_sat)
    );

    // acc_q already holds the last product once p2_last_q is set; shift floors toward -inf.
    assign acc_sh     = acc_q >>> Q;
    assign flush_done = (state_q == FLUSH) && p2_last_q;

    always_comb begin
        fin_res   = acc_sh[31:0];
        fin_clamp = 1'b0;
        if (acc_sh > fp_64_t'(FP32_MAX)) begin
            fin_res   = FP32_MAX;
            fin_clamp = 1'b1;
        end else if (acc_sh < fp_64_t'(FP32_MIN)) begin
            fin_res   = FP32_MIN;
            fin_clamp = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCUM: begin
                in_ready_d = 1'b1;
                if (accept && in_last) begin
                    state_d    = FLUSH;
                    in_ready_d = 1'b0;
                end
            end
            FLUSH: begin
                in_ready_d = 1'b0;
                if (p2_last_q) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                end
            end
            HOLD: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ACCUM;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ACCUM;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            p1_vld_q     <= 1'b0;
            p1_last_q    <= 1'b0;
            p1_prod_q    <= '0;
            p2_last_q    <= 1'b0;
            acc_q        <= '0;
            sat_acc_q    <= 1'b0;
            cnt_q        <= '0;
            result_q     <= '0;
            term_count_q <= '0;
            sat_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;

            // P1: product register
            p1_vld_q  <= accept;
            p1_last_q <= accept && in_last;
            if (accept) begin
                p1_prod_q <= prod;
            end

            // P2: accumulate; flush clears the running state in the same edge it is consumed
            p2_last_q <= p1_vld_q && p1_last_q;
            if (flush_done) begin
                acc_q     <= '0;
                sat_acc_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                if (p1_vld_q) begin
                    acc_q     <= acc_sum;
                    sat_acc_q <= sat_acc_q | acc_sat;
                end
                if (accept && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            if (flush_done) begin
                result_q     <= fin_res;
                term_count_q <= cnt_q;
                sat_q        <= sat_acc_q | fin_clamp;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign term_count = term_count_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_vs_fp_dot_acc.sv
`timescale 1ns/1ps
module tb_vs_fp_dot_acc;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        in_ready, out_valid, sat;
    logic [31:0] result;
    logic [15:0] term_count;

    int n_checks = 0;
    int n_errors = 0;
    int va [64];
    int vb [64];

    always #5 clock = ~clock;

    vs_fp_dot_acc #(.Q(15), .CNT_W(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .term_count (term_count),
        .sat        (sat)
    );

    // Reference: exact wide arithmetic, clamp after every add, floor shift, final clamp.
    function automatic void model(input int n, output logic [31:0] r, output logic s);
        logic signed [127:0] acc, p, sh, mx64, mx32;
        mx64 = (128'sd1 <<< 63) - 128'sd1;
        mx32 = (128'sd1 <<< 31) - 128'sd1;
        acc  = '0;
        s    = 1'b0;
        for (int i = 0; i < n; i++) begin
            p   = longint'(va[i]) * longint'(vb[i]);
            acc = acc + p;
            if (acc > mx64) begin acc = mx64; s = 1'b1; end
            else if (acc < -mx64) begin acc = -mx64; s = 1'b1; end
        end
        sh = acc >>> 15;
        if (sh > mx32) begin sh = mx32; s = 1'b1; end
        else if (sh < -mx32) begin sh = -mx32; s = 1'b1; end
        r = sh[31:0];
    endfunction

    // Drives va/vb[0..n-1] as one vector, returns edges from last accept to out_valid.
    task automatic send_vec(input int n, input int gap_max, output int lat, output bit to);
        int b;
        to = 1'b0;
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin @(negedge clock); in_valid = 1'b0; end
            @(negedge clock);
            in_valid = 1'b1;
            a_in     = va[i];
            b_in     = vb[i];
            in_last  = (i == n - 1);
            b = 0;
            while (!in_ready && b < 100) begin @(negedge clock); b++; end
            if (b >= 100) to = 1'b1;
            @(posedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clock); lat++; end
        if (lat >= 50) to = 1'b1;
    endtask

    // Completes the result handshake; returns on the negedge after it.
    task automatic release_out;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || term_count !== 16'd0 || sat !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_vals: in_ready=%b out_valid=%b result=%h term_count=%0d sat=%b, need all zero",
                     in_ready, out_valid, result, term_count, sat);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_before_edge: in_ready=%b need 0", in_ready);
        end
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_edge: in_ready=%b need 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int lat; bit to;
        va[0] = 32768;  vb[0] = 32768;
        va[1] = 16384;  vb[1] = 65536;
        va[2] = -8192;  vb[2] = 32768;
        send_vec(3, 0, lat, to);
        n_checks++;
        if (to || lat != 2) begin
            n_errors++;
            $display("FAIL basic_latency: got %0d timeout=%b need 2", lat, to);
        end
        n_checks++;
        if (result !== 32'd57344 || term_count !== 16'd3 || sat !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_result: result=%0d tc=%0d sat=%b need 57344 3 0", result, term_count, sat);
        end
        release_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single_neg;
        int lat; bit to;
        va[0] = -1; vb[0] = 1;
        send_vec(1, 0, lat, to);
        n_checks++;
        if (to || lat != 2 || result !== 32'hFFFF_FFFF || term_count !== 16'd1 || sat !== 1'b0) begin
            n_errors++;
            $display("FAIL single_neg: lat=%0d result=%h tc=%0d sat=%b need 2 ffffffff 1 0", lat, result, term_count, sat);
        end
        release_out();
    endtask

    task automatic test_saturate_and_clear;
        int lat; bit to;
        for (int i = 0; i < 4; i++) begin va[i] = 32'h7FFF_FFFF; vb[i] = 32'h7FFF_FFFF; end
        send_vec(4, 0, lat, to);
        n_checks++;
        if (to || result !== 32'h7FFF_FFFF || term_count !== 16'd4 || sat !== 1'b1) begin
            n_errors++;
            $display("FAIL saturate: result=%h tc=%0d sat=%b need 7fffffff 4 1", result, term_count, sat);
        end
        release_out();
        va[0] = 32768; vb[0] = 32768;
        send_vec(1, 0, lat, to);
        n_checks++;
        if (to || result !== 32'd32768 || term_count !== 16'd1 || sat !== 1'b0) begin
            n_errors++;
            $display("FAIL sticky_clear: result=%0d tc=%0d sat=%b need 32768 1 0", result, term_count, sat);
        end
        release_out();
    endtask

    task automatic test_clamp_min;
        int lat; bit to;
        va[0] = 32'h8000_0001; vb[0] = 32'h7FFF_FFFF;
        send_vec(1, 0, lat, to);
        n_checks++;
        if (to || result !== 32'h8000_0001 || term_count !== 16'd1 || sat !== 1'b1) begin
            n_errors++;
            $display("FAIL clamp_min: result=%h tc=%0d sat=%b need 80000001 1 1", result, term_count, sat);
        end
        release_out();
    endtask

    task automatic test_backpressure;
        int lat; bit to;
        va[0] = 65536; vb[0] = 98304;
        send_vec(1, 0, lat, to);
        n_checks++;
        if (to || result !== 32'd196608 || term_count !== 16'd1 || sat !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_result: result=%0d tc=%0d sat=%b need 196608 1 0", result, term_count, sat);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd196608 || term_count !== 16'd1 || sat !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b result=%0d tc=%0d sat=%b", c,
                         out_valid, in_ready, result, term_count, sat);
            end
        end
        release_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random;
        int lat, n, hold, mode; bit to;
        logic [31:0] er; logic es;
        for (int v = 0; v < 25; v++) begin
            n    = $urandom_range(8, 1);
            mode = $urandom_range(2, 0);
            for (int i = 0; i < n; i++) begin
                case (mode)
                    0:       begin va[i] = int'($urandom_range(2097151, 0)) - 1048576;   vb[i] = int'($urandom_range(2097151, 0)) - 1048576; end
                    1:       begin va[i] = int'($urandom_range(134217727, 0)) - 67108864; vb[i] = int'($urandom_range(134217727, 0)) - 67108864; end
                    default: begin va[i] = $urandom; vb[i] = $urandom; end
                endcase
            end
            model(n, er, es);
            send_vec(n, 2, lat, to);
            n_checks++;
            if (to || lat != 2) begin
                n_errors++;
                $display("FAIL rand_latency v%0d: got %0d timeout=%b need 2", v, lat, to);
            end
            n_checks++;
            if (result !== er || term_count !== 16'(n) || sat !== es) begin
                n_errors++;
                $display("FAIL rand_result v%0d: result=%h tc=%0d sat=%b need %h %0d %b", v, result, term_count, sat, er, n, es);
            end
            hold = $urandom_range(3, 0);
            repeat (hold) begin
                @(negedge clock);
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || sat !== es) begin
                    n_errors++;
                    $display("FAIL rand_hold v%0d: out_valid=%b in_ready=%b result=%h sat=%b", v, out_valid, in_ready, result, sat);
                end
            end
            release_out();
        end
    endtask

    task automatic test_async_reset;
        int lat, b; bit to;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            in_valid = 1'b1; a_in = 32'd12345; b_in = 32'd54321; in_last = 1'b0;
            b = 0;
            while (!in_ready && b < 100) begin @(negedge clock); b++; end
            @(posedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || term_count !== 16'd0 || sat !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b result=%h tc=%0d sat=%b need all zero",
                     in_ready, out_valid, result, term_count, sat);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        va[0] = 32768; vb[0] = 32768;
        send_vec(1, 0, lat, to);
        n_checks++;
        if (to || result !== 32'd32768 || term_count !== 16'd1 || sat !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset: result=%0d tc=%0d sat=%b need 32768 1 0", result, term_count, sat);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_neg();
        test_saturate_and_clear();
        test_clamp_min();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vs_fp_dot_acc.md
Name: vs_fp_dot_acc

Overview:
- Streaming dot-product accumulator for Q-format fixed point, 2's complement, 32-bit signed elements.
- Accepts (a, b) element pairs over a valid/ready handshake and multiplies them into a 64-bit product.
- Accumulates the products with saturation, and on the last element of a vector emits one 32-bit result (acc >>> Q, clamped) over a second valid/ready handshake.
- Sits between the operand feeders and result write-back, as the sequential counterpart to the element-wise multiply and MAC processing elements.

Parameters:
- Q, 15, number of fractional bits in operands and result.
- CNT_W, 16, width of the per-vector term counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, active-low
- in_valid  in  1  a_in/b_in/in_last valid
- in_ready  out  1  block can accept an element (registered)
- a_in  in  32  operand A, fp_32_t
- b_in  in  32  operand B, fp_32_t
- in_last  in  1  element is the final term of the current vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  fp_32_t dot product, Q fractional bits
- term_count  out  CNT_W  number of terms in the emitted vector
- sat  out  1  saturation occurred in accumulation or final clamp for this vector

Behaviour:
- Reset is asynchronous, active-low: one clock; reset is asynchronous and active-low, on ports clock and reset_n.
- Reset values: in_ready=0, out_valid=0, result=0, term_count=0, sat=0, accumulator=0, counter=0, state=ACCUM, pipeline valid bits=0.
- in_ready rises on the first rising edge with reset_n high.
- Accept condition: in_valid && in_ready.
- Pipeline:
  - P1 registers the product fp_64_t'(a_in) * fp_64_t'(b_in), a full signed 64-bit product, together with its last flag.
  - P2 adds it into the accumulator with 64-bit saturating add. Bounds are FP64_MAX and FP64_MIN = -(2^63-1). Clamping sets the sticky sat_acc bit.
- Latency: element accepted at edge t, product registered at t+1, accumulated at t+2. For a last element, out_valid=1 at t+2 with result, term_count and sat.
- Result computation: final sum S = sat_add(acc, product_last). Apply an arithmetic right shift by Q (truncation toward -inf, no rounding). Clamp to [FP32_MIN = -(2^31-1), FP32_MAX = 2^31-1].
- sat = sat_acc OR clamp occurred.
- Counter: increments per accepted element and saturates at 2^CNT_W-1, with no wrap. term_count reports the count including the last element.
- States:
  - ACCUM: in_ready=1. On accept with in_last, go to FLUSH and in_ready=0 from the next cycle.
  - FLUSH: in_ready=0. Wait until the last product is accumulated, then load the output registers, set out_valid=1, and go to HOLD. The accumulator, counter and sat_acc clear in the same edge.
  - HOLD: out_valid=1, and result/term_count/sat are held stable. On out_valid && out_ready, set out_valid=0, in_ready=1 and go to ACCUM on the next edge.
- No bypass: a new element cannot be accepted in the handshake cycle.
- in_valid while in_ready=0 is ignored. The source must hold its data.
- out_ready while out_valid=0 has no effect.
- Single-term vector (in_last on the first element) is legal: result = sat32(a*b >>> Q), term_count=1.
- Reset mid-vector or in HOLD discards all partial state; no result is emitted.

Decomposition:
- Package vs_fp_pkg holds:
  - fp_32_t and fp_64_t typedefs;
  - constants FP32_MAX, FP32_MIN, FP64_MAX, FP64_MIN;
  - the enum typedef for the state (ACCUM, FLUSH, HOLD).
- One combinational sub-module, vs_fp_sadd64: 64-bit saturating adder, outputs sum and a saturated flag. It is used in P2.
- The final shift-and-clamp stays inline.

Test Plan:
- Q=15. Send (32768,32768), (16384,65536), (-8192,32768) with last on the third -> out_valid 2 cycles after the third accept. Expected result=57344 (1.75), term_count=3, sat=0.
- Single term (-1,1) with last -> result=0xFFFFFFFF (-1, truncation toward -inf), term_count=1, sat=0.
- Four terms of (0x7FFFFFFF,0x7FFFFFFF) -> accumulator saturates at FP64_MAX. Expected result=0x7FFFFFFF and sat=1. A following vector (32768,32768) gives result=32768, sat=0, which confirms the sticky bit cleared.
- Single term (0x80000001,0x7FFFFFFF) -> product exceeds the 32-bit range after the shift. Expected result=FP32_MIN=0x80000001, sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result, term_count and sat are stable, and in_ready=0 throughout. The cycle after out_ready=1: out_valid=0, in_ready=1.
- Deassert reset_n asynchronously after two accepted non-last terms -> all outputs read 0 immediately and in_ready=0. After reset release, vector (32768,32768) with last -> result=32768, term_count=1.
